// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkbuf_en_seq_if.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__clkbuf_en_seq_if.sv - target-mask valid/ready handshake
interface gf180mcu_fd_sc_mcu9t5v0__clkbuf_en_seq_if #(
    parameter int NBR = 4
);
    logic [NBR-1:0] TGT;
    logic           TGT_VLD;
    logic           TGT_RDY;

    modport master (output TGT, output TGT_VLD, input  TGT_RDY);
    modport slave  (input  TGT, input  TGT_VLD, output TGT_RDY);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkbuf_en_seq.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__clkbuf_en_seq.sv - one-branch-at-a-time clock-buffer enable sequencer
module gf180mcu_fd_sc_mcu9t5v0__clkbuf_en_seq #(
    parameter int NBR = 4,
    parameter int GAP = 3
) (
    input  logic                                          CLK,
    input  logic                                          RN,
    gf180mcu_fd_sc_mcu9t5v0__clkbuf_en_seq_if.slave       tgt_if,
    input  logic                                          FORCE_OFF,
    output logic [NBR-1:0]                                EN,
    output logic                                          BUSY,
    output logic                                          DONE
);
    localparam int CW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [NBR-1:0] en_q, en_d;
    logic [NBR-1:0] tgt_q, tgt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [NBR-1:0] mism;
    logic [NBR-1:0] flip;

    // Two's-complement trick isolates the lowest mismatched bit as a one-hot mask.
    assign mism = en_q ^ tgt_q;
    assign flip = mism & (~mism + NBR'(1));

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (FORCE_OFF) begin
            state_d = IDLE;
            en_d    = '0;
            tgt_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tgt_if.TGT_VLD) begin
                        tgt_d = tgt_if.TGT;
                        if (tgt_if.TGT == en_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = STEP;
                        end
                    end
                end
                STEP: begin
                    if (mism == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        en_d    = en_q ^ flip;
                        cnt_d   = CW'(GAP - 1);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    // Returning through STEP adds the edge that makes toggles GAP+1 apart.
                    if (cnt_q == '0) begin
                        state_d = STEP;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            en_q    <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign EN             = en_q;
    assign DONE           = done_q;
    assign BUSY           = (state_q != IDLE);
    assign tgt_if.TGT_RDY = (state_q == IDLE) & ~FORCE_OFF;
endmodule
